ring_counter_param: RTL and testbench

Parametrised successor to the fixed 4-bit ring counter. It adds configurable width, run-time ring/Johnson mode, direction control, enable, parallel load and a wrap pulse. It is used as a phase/sequencer source for downstream one-hot or thermometer-decoded control. All state is in one clock domain.

---
 rtl/ring_counter_pkg.sv | 16 +
 rtl/ring_state_check.sv | 25 ++
 rtl/ring_counter_param.sv | 96 +++++++++
 tb/tb_ring_counter_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// Shared constants and the home-value helper for the parametrised ring/Johnson counter.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

    // Home is a single one in bit 0 for ring mode, all zeros for Johnson mode.
    function automatic logic [31:0] home_val(input logic mode, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (mode == MODE_RING) ? (32'd1 & mask) : 32'd0;
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality check of a ring (one-hot) or Johnson (anchored run) pattern.
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic             valid
);

    logic [WIDTH-1:0] inv;

    // A run anchored at bit 0 is 2^k-1; one anchored at the MSB is the complement of that.
    always_comb begin
        inv = ~count;
        if (mode == MODE_RING) begin
            valid = (count != '0) && ((count & (count - WIDTH'(1))) == '0);
        end else begin
            valid = ((count & (count + WIDTH'(1))) == '0) ||
                    ((inv & (inv + WIDTH'(1))) == '0);
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised ring/Johnson counter with direction, enable, load and wrap pulse.
// Optional illegal-state correction enabled by RING_COUNTER_SELF_CORRECT_EN.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             err
);

    logic [WIDTH-1:0] home_cur;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] count_d;
    logic             mode_q;
    logic             wrap_d;
    logic             valid;

    assign home_cur = WIDTH'(home_val(mode, WIDTH));

`ifdef RING_COUNTER_SELF_CORRECT_EN
    logic err_d;

    ring_state_check #(.WIDTH(WIDTH)) u_check (
        .count (count),
        .mode  (mode_q),
        .valid (valid)
    );
`else
    assign valid = 1'b1;
    assign err   = 1'b0;
`endif

    // Single step in the current mode and direction.
    always_comb begin
        step_val = count;
        if (mode_q == MODE_RING) begin
            if (dir == DIR_LEFT) step_val = {count[WIDTH-2:0], count[WIDTH-1]};
            else                 step_val = {count[0], count[WIDTH-1:1]};
        end else begin
            if (dir == DIR_LEFT) step_val = {count[WIDTH-2:0], ~count[WIDTH-1]};
            else                 step_val = {~count[0], count[WIDTH-1:1]};
        end
    end

    // Priority: mode change > load > enabled step (or correction) > hold.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
`ifdef RING_COUNTER_SELF_CORRECT_EN
        err_d   = 1'b0;
`endif
        if (mode_q != mode) begin
            count_d = home_cur;
        end else if (ld) begin
            count_d = ld_val;
        end else if (en) begin
            if (!valid) begin
                count_d = home_cur;
`ifdef RING_COUNTER_SELF_CORRECT_EN
                err_d   = 1'b1;
`endif
            end else begin
                count_d = step_val;
                wrap_d  = (step_val == home_cur);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= home_cur;
            mode_q <= mode;
            wrap   <= 1'b0;
`ifdef RING_COUNTER_SELF_CORRECT_EN
            err    <= 1'b0;
`endif
        end else begin
            count  <= count_d;
            mode_q <= mode;
            wrap   <= wrap_d;
`ifdef RING_COUNTER_SELF_CORRECT_EN
            err    <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param at WIDTH=4; follows RING_COUNTER_SELF_CORRECT_EN.
module tb_ring_counter_param;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         en;
    logic         dir;
    logic         mode;
    logic         ld;
    logic [W-1:0] ld_val;
    logic [W-1:0] count;
    logic         wrap;
    logic         err;

    int checks   = 0;
    int failures = 0;

    logic [W+1:0] sb_q[$];
    logic [W-1:0] m_count;
    logic         m_mode;

    ring_counter_param #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .dir    (dir),
        .mode   (mode),
        .ld     (ld),
        .ld_val (ld_val),
        .count  (count),
        .wrap   (wrap),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] m_home(input logic md);
        return (md == 1'b0) ? W'(1) : W'(0);
    endfunction

    // Legal if ring has one bit set, or Johnson has at most one adjacent-bit transition.
    function automatic logic m_valid(input logic [W-1:0] c, input logic md);
        int ones;
        int edges;
        ones = 0;
        edges = 0;
        for (int i = 0; i < W; i++) if (c[i]) ones++;
        for (int i = 0; i < W - 1; i++) if (c[i] != c[i+1]) edges++;
        return (md == 1'b0) ? (ones == 1) : (edges <= 1);
    endfunction

    function automatic logic [W-1:0] m_step(input logic [W-1:0] c, input logic md, input logic d);
        logic feed;
        if (d == 1'b0) begin
            feed = md ? ~c[W-1] : c[W-1];
            return (c << 1) | W'(feed);
        end else begin
            feed = md ? ~c[0] : c[0];
            return (c >> 1) | (W'(feed) << (W - 1));
        end
    endfunction

    // Drive one cycle, predict the outcome, then compare what the DUT produces.
    task automatic drive(input logic r, input logic e, input logic d, input logic md,
                         input logic l, input logic [W-1:0] v);
        logic [W-1:0] nc;
        logic         nw;
        logic         ne;
        logic         bad;
        logic [W+1:0] exp;
        reset = r; en = e; dir = d; mode = md; ld = l; ld_val = v;
        nc = m_count; nw = 1'b0; ne = 1'b0; bad = 1'b0;
        if (r) begin
            nc = m_home(md);
            m_mode = md;
        end else if (m_mode != md) begin
            nc = m_home(md);
            m_mode = md;
        end else if (l) begin
            nc = v;
        end else if (e) begin
`ifdef RING_COUNTER_SELF_CORRECT_EN
            bad = !m_valid(m_count, m_mode);
`endif
            if (bad) begin
                nc = m_home(m_mode);
                ne = 1'b1;
            end else begin
                nc = m_step(m_count, m_mode, d);
                nw = (nc == m_home(m_mode));
            end
        end
        m_count = nc;
        sb_q.push_back({nc, nw, ne});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check("count", 32'(count), 32'(exp[W+1:2]));
        check("wrap",  32'(wrap),  32'(exp[1]));
        check("err",   32'(err),   32'(exp[0]));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; ld = 1'b0; ld_val = '0;
        m_count = '0;
        m_mode = 1'b0;
        @(negedge clk);

        // Ring left from reset.
        drive(1, 0, 0, 0, 0, 4'h0);
        check("tp_reset_home", 32'(count), 32'h1);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 4'h0);
        check("tp_ring_wrap_count", 32'(count), 32'h1);
        check("tp_ring_wrap", 32'(wrap), 32'h1);

        // Johnson left from reset: wrap only on the 8th step.
        drive(1, 0, 0, 1, 0, 4'h0);
        for (int i = 0; i < 7; i++) drive(0, 1, 0, 1, 0, 4'h0);
        check("tp_john_step7", 32'(count), 32'h8);
        check("tp_john_step7_wrap", 32'(wrap), 32'h0);
        drive(0, 1, 0, 1, 0, 4'h0);
        check("tp_john_step8", 32'(count), 32'h0);
        check("tp_john_step8_wrap", 32'(wrap), 32'h1);

        // Ring right, then hold.
        drive(1, 0, 0, 0, 0, 4'h0);
        drive(0, 1, 1, 0, 0, 4'h0);
        check("tp_right_first", 32'(count), 32'h8);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 4'h0);
        check("tp_right_wrap", 32'(wrap), 32'h1);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 4'h0);
        check("tp_hold", 32'(count), 32'h1);

        // Load beats enable; load to home gives no wrap.
        drive(0, 1, 0, 0, 1, 4'h4);
        check("tp_load", 32'(count), 32'h4);
        drive(0, 1, 0, 0, 0, 4'h0);
        check("tp_load_step", 32'(count), 32'h8);
        drive(0, 1, 0, 0, 1, 4'h1);
        check("tp_load_home_wrap", 32'(wrap), 32'h0);

        // Mode change ignores en/ld; reset mid-Johnson returns home.
        drive(0, 0, 0, 0, 1, 4'h4);
        drive(0, 1, 0, 1, 1, 4'h2);
        check("tp_mode_change", 32'(count), 32'h0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0, 4'h0);
        check("tp_john_0111", 32'(count), 32'h7);
        drive(1, 1, 0, 1, 0, 4'h0);
        check("tp_reset_mid", 32'(count), 32'h0);

        // Illegal ring pattern loaded then stepped.
        drive(0, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 0, 0, 1, 4'h6);
        drive(0, 1, 0, 0, 0, 4'h0);
`ifdef RING_COUNTER_SELF_CORRECT_EN
        check("tp_correct_count", 32'(count), 32'h1);
        check("tp_correct_err", 32'(err), 32'h1);
`else
        check("tp_rotate_count", 32'(count), 32'hC);
        check("tp_rotate_err", 32'(err), 32'h0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 19) == 0) ? ~m_mode : m_mode,
                  ($urandom_range(0, 9) == 0), W'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
